// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel fetch path.
package vga_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    typedef logic [7:0] pixel_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead word FIFO: head is the oldest entry, readable combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches 32-bit image words from memory and unpacks them little-endian
// into one 8-bit pixel per pix_req for the VGA colour stage.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                     IMG_W         = 160,
    parameter int                     IMG_H         = 120,
    parameter int                     FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     pix_req,
    output logic [7:0]               pix_data,
    output logic                     pix_valid,
    output logic                     underflow,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic                     mem_re,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);

    localparam int TOTAL_WORDS = (IMG_W * IMG_H) / BYTES_PER_WORD;
    localparam int WC_W        = $clog2(TOTAL_WORDS + 1);
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic                     underflow_q, underflow_d;

    logic                     fifo_push, fifo_pop, fifo_flush;
    logic                     fifo_empty, fifo_full;
    logic [DATA_WIDTH-1:0]    fifo_head;
    logic [CNT_W-1:0]         fifo_count;
    logic                     consume;
    pixel_t                   head_byte;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (mem_RD),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_byte = fifo_head[{byte_idx_q, 3'b000} +: 8];
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head_byte : 8'h00;
    assign underflow = underflow_q;
    assign mem_A     = mem_a_q;
    assign consume   = pix_req && pix_valid && !frame_start;
    assign fifo_pop  = consume && (byte_idx_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        mem_a_d     = mem_a_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        underflow_d = underflow_q;
        mem_re      = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;

        if (frame_start) begin
            // Restart wins over everything; an in-flight word is dropped by not pushing it.
            fifo_flush  = 1'b1;
            state_d     = REQ;
            mem_a_d     = BASE_ADDR;
            word_cnt_d  = '0;
            byte_idx_d  = '0;
            underflow_d = 1'b0;
        end else begin
            if (pix_req && !pix_valid) underflow_d = 1'b1;
            if (consume)               byte_idx_d  = byte_idx_q + 2'd1;

            case (state_q)
                REQ: begin
                    if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                        mem_re  = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    fifo_push  = !fifo_full || fifo_pop;
                    mem_a_d    = mem_a_q + ADDRESS_WIDTH'(BYTES_PER_WORD);
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    state_d    = (word_cnt_q == WC_W'(TOTAL_WORDS - 1)) ? DONE : REQ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_a_q     <= BASE_ADDR;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_a_q     <= mem_a_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: full-size image instance plus an 8x1 instance for end-of-frame.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        fs, req, pv, uf, mre;
    logic [7:0]  pd;
    logic [31:0] ma, mrd;
    logic        fs_s, req_s, pv_s, uf_s, mre_s;
    logic [7:0]  pd_s;
    logic [31:0] ma_s, mrd_s;

    vga_pixel_fetch dut (
        .clk(clk), .rst(rst), .frame_start(fs), .pix_req(req), .pix_data(pd),
        .pix_valid(pv), .underflow(uf), .mem_A(ma), .mem_re(mre), .mem_RD(mrd)
    );

    vga_pixel_fetch #(.IMG_W(8), .IMG_H(1)) dut_s (
        .clk(clk), .rst(rst), .frame_start(fs_s), .pix_req(req_s), .pix_data(pd_s),
        .pix_valid(pv_s), .underflow(uf_s), .mem_A(ma_s), .mem_re(mre_s), .mem_RD(mrd_s)
    );

    // Image byte at address b is (b+1)*0x11 mod 256: 11,22,...,88,99,...
    function automatic logic [7:0] img_byte(input logic [31:0] b);
        return 8'((b + 32'd1) * 32'h11);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {img_byte(a + 3), img_byte(a + 2), img_byte(a + 1), img_byte(a)};
    endfunction

    // Memory returns data one cycle after mem_re, junk otherwise.
    always @(posedge clk) begin
        mrd   <= mre   ? word_at(ma)   : 32'hDEAD_BEEF;
        mrd_s <= mre_s ? word_at(ma_s) : 32'hDEAD_BEEF;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step(input logic f, input logic r);
        @(negedge clk);
        fs  = f;
        req = r;
        #1;
    endtask

    typedef struct {
        logic        fs;
        logic        req;
        logic        mre;
        logic [31:0] ma;
        logic        pv;
        logic [7:0]  pd;
        logic        uf;
    } vec_t;

    vec_t vecs[12];
    int   cnt, bad;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd4,  1'b1, 8'h22, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 8'h33, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd8,  1'b1, 8'h44, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 8'h55, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd12, 1'b1, 8'h66, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 8'h77, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 8'h88, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 8'h99, 1'b0};

        rst = 1'b0; fs = 1'b0; req = 1'b0; fs_s = 1'b0; req_s = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", {pv, pd, uf, mre, ma}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("idle no fetch", {pv, mre, ma}, 64'd0);

        // Streaming: frame_start, then consume every cycle once valid.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].fs, vecs[i].req);
            check($sformatf("stream vec%0d {mre,mA,valid,data,uf}", i),
                  {mre, ma, pv, pd, uf},
                  {vecs[i].mre, vecs[i].ma, vecs[i].pv, vecs[i].pd, vecs[i].uf});
        end

        // No consumption: fetch stops after FIFO_DEPTH reads.
        step(1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (mre) cnt++;
        end
        check("stall mem_re pulses", 64'(cnt), 64'd4);
        check("stall {valid,data,uf}", {pv, pd, uf}, {1'b1, 8'h11, 1'b0});
        check("stall mem_A", 64'(ma), 64'd16);

        // Asynchronous reset mid-frame.
        #2 rst = 1'b0;
        #1;
        check("async reset outputs", {pv, pd, uf, mre, ma}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (mre || pv) bad++;
        end
        check("post-reset idle cycles", 64'(bad), 64'd0);

        // Requests from frame_start onward: underflow, data held at 0 while invalid.
        step(1'b1, 1'b1);
        check("uf frame_start cycle", 64'(uf), 64'd0);
        step(1'b0, 1'b1);
        check("uf cycle1 {valid,data}", {pv, pd}, 9'd0);
        step(1'b0, 1'b1);
        check("uf cycle2 {uf,valid,data}", {uf, pv, pd}, {1'b1, 1'b0, 8'h00});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            if (!uf || (!pv && pd != 8'h00)) bad++;
        end
        check("uf sticky / zero data when invalid", 64'(bad), 64'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("uf cleared by frame_start", 64'(uf), 64'd0);

        // frame_start during WAIT discards the in-flight word.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("restart REQ mem_re", 64'(mre), 64'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("restart {mre,mA,valid}", {mre, ma, pv}, {1'b1, 32'd0, 1'b0});
        step(1'b0, 1'b0);
        check("restart wait valid", 64'(pv), 64'd0);
        step(1'b0, 1'b0);
        check("restart first pixel", {pv, pd}, {1'b1, 8'h11});

        // 8x1 image: two reads, then DONE; a 9th request underflows.
        @(negedge clk); fs_s = 1'b1; #1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); fs_s = 1'b0; #1;
            if (mre_s) cnt++;
        end
        check("small mem_re pulses", 64'(cnt), 64'd2);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); req_s = 1'b1; #1;
            if (mre_s) cnt++;
            check($sformatf("small pixel %0d {valid,data}", i), {pv_s, pd_s},
                  {1'b1, img_byte(32'(i))});
        end
        check("small no refetch in DONE", 64'(cnt), 64'd0);
        @(negedge clk); req_s = 1'b1; #1;
        check("small 9th valid", 64'(pv_s), 64'd0);
        @(negedge clk); req_s = 1'b0; #1;
        check("small 9th underflow", {uf_s, mre_s}, {1'b1, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
